// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period of a slow square wave that is asynchronous to clk_i.
// The result is expressed in clk_i cycles. sig_i is synchronised and its
// rising edges are detected. Each completed period is published on period_o
// together with a one-cycle valid_o strobe. If no edge arrives within TIMEOUT
// cycles of the previous one, the sticky timeout_o flag is raised and the
// meter re-arms on the next edge.
//
// Parameters:
//   CNT_W    - width of the period counter and of period_o
//   TIMEOUT  - cycle count at which a missing edge becomes a timeout
//              (2 <= TIMEOUT <= 2**CNT_W - 1)
//
// Ports:
//   clk_i     in   1      system clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   sig_i     in   1      measured signal, asynchronous to clk_i
//   period_o  out  CNT_W  last measured period, held between updates
//   valid_o   out  1      one-cycle pulse when period_o is updated
//   timeout_o out  1      sticky loss-of-signal flag, cleared by next valid_o
//
// Optional feature (macro PERIOD_METER_AVG_EN):
//   When defined, period_o reports the truncated mean of the last four raw
//   periods. valid_o is withheld until four raw periods have been collected
//   since reset or since the last timeout.
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int CNT_W   = 17,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;

    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             rise;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] period_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;

    // A rise while measuring closes one raw period.
    logic             capture;
    // The measurement window expired without a rise.
    logic             expire;

`ifdef PERIOD_METER_AVG_EN
    // hist[0] is the newest raw period and hist[3] the oldest. Unfilled slots
    // hold zero, so subtracting hist[3] is harmless before the window is full.
    logic [CNT_W-1:0] hist     [4];
    logic [CNT_W-1:0] hist_nxt [4];
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] sum_nxt;
    logic [2:0]       fill;
    logic [2:0]       fill_nxt;
`endif

    // Two flops resynchronise sig_i. The third flop keeps one cycle of history
    // for edge detection. rise is registered as well, so a transition sampled
    // at edge k is seen by the FSM at edge k+3.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= sig_i;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state and measurement control. cnt holds (cycles since last rise)-1,
    // so cnt_inc is the period when the next rise arrives. A rise that coincides
    // with the timeout count wins and is reported as a period of TIMEOUT cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        expire    = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    cnt_nxt = '0;
                    capture = 1'b1;
                end else if (cnt_inc == TIMEOUT_C) begin
                    cnt_nxt   = '0;
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output publication. A published value always clears the timeout flag,
    // and an expiry sets it without touching period_o.
    always_comb begin
        period_nxt  = period_o;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout_o;
`ifdef PERIOD_METER_AVG_EN
        hist_nxt = hist;
        sum_nxt  = sum;
        fill_nxt = fill;
`endif

        if (capture) begin
`ifdef PERIOD_METER_AVG_EN
            sum_nxt     = sum - {2'b00, hist[3]} + {2'b00, cnt_inc};
            hist_nxt[3] = hist[2];
            hist_nxt[2] = hist[1];
            hist_nxt[1] = hist[0];
            hist_nxt[0] = cnt_inc;
            fill_nxt    = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
            if (fill_nxt == 3'd4) begin
                period_nxt  = sum_nxt[CNT_W+1:2];
                valid_nxt   = 1'b1;
                timeout_nxt = 1'b0;
            end
`else
            period_nxt  = cnt_inc;
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b0;
`endif
        end else if (expire) begin
            timeout_nxt = 1'b1;
`ifdef PERIOD_METER_AVG_EN
            for (int i = 0; i < 4; i++) begin
                hist_nxt[i] = '0;
            end
            sum_nxt  = '0;
            fill_nxt = 3'd0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
            sum  <= '0;
            fill <= 3'd0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            period_o  <= period_nxt;
            valid_o   <= valid_nxt;
            timeout_o <= timeout_nxt;
`ifdef PERIOD_METER_AVG_EN
            hist <= hist_nxt;
            sum  <= sum_nxt;
            fill <= fill_nxt;
`endif
        end
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of a slow, asynchronous square wave (e.g. the divided clock or an external strobe) in units of `clk_i` cycles. It sits in the fast `clk_i` domain and is the receiving end of a clock-divider output: it synchronises the slow signal and detects its rising edges. On each completed period it publishes the cycle count with a one-cycle valid strobe, and it flags loss of signal with a timeout.

## Interface
- `CNT_W`, 17 — width of the period counter and of `period_o`.
- `TIMEOUT`, 100000 — cycle count at which a missing edge is declared a timeout; must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.
- `clk_i` input 1 — system clock; all logic is on the rising edge.
- `rst_n` input 1 — reset, synchronous and active-low.
- `sig_i` input 1 — measured signal; asynchronous to `clk_i`.
- `period_o` output CNT_W — last measured period in `clk_i` cycles; holds its value between updates.
- `valid_o` output 1 — one-cycle pulse when `period_o` is updated.
- `timeout_o` output 1 — sticky level; high after a timeout until the next valid measurement.

## Operation
- Input path: 2-flop synchroniser on `sig_i`, then a third flop for edge history. `rise` = sync2 & ~sync3.
- Counter `cnt` (CNT_W bits): cleared to 0 in the cycle `rise` is seen; otherwise increments in MEASURE; held at 0 in IDLE.
- FSM:
  - IDLE: waits for the first `rise`. No output change. On `rise`, go to MEASURE with `cnt` = 0.
  - MEASURE on `rise`: load `period_o` with cnt+1 (N = distance in cycles between consecutive rises). Pulse `valid_o`, clear `timeout_o`, set `cnt` = 0, stay in MEASURE.
  - MEASURE with no `rise` and cnt+1 == TIMEOUT: set `timeout_o`, go to IDLE, set `cnt` = 0. `period_o` is unchanged and no `valid_o` pulse is issued.
- Simultaneous `rise` and timeout condition: the `rise` wins; it is a valid measurement of TIMEOUT cycles.
- The counter never wraps, because the timeout fires first.
- Arithmetic: cnt+1 is computed at CNT_W bits; no overflow is possible given the TIMEOUT bound.

## Timing
- Reset (rst_n = 0 at a rising clock edge):
  - synchroniser flops, `cnt`, `period_o`, `valid_o` and `timeout_o` go to 0;
  - FSM goes to IDLE;
  - this applies from any state, including mid-measurement.
- If `sig_i` is high out of reset, a `rise` is detected 2 cycles later. It only arms the FSM and produces no output.
- Latency: a `sig_i` rising transition sampled at edge k produces `rise` at edge k+2. `period_o`/`valid_o` update at edge k+3.
- `valid_o` is high for exactly one cycle per measurement. There is no back-pressure, so a consumer must capture `period_o` in that cycle or later, before the next measurement.
- The minimum measurable period is 2 cycles. High/low phases shorter than 1 cycle may be missed, and this is acceptable.
- `timeout_o` rises in the cycle after cnt+1 reaches TIMEOUT. It falls together with the next `valid_o` pulse.

## Configuration
- Macro: `PERIOD_METER_AVG_EN`.
- Defined: the block keeps a 4-entry history of raw periods and a running sum of CNT_W+2 bits.
  - `period_o` = sum >> 2, truncated.
  - `valid_o` pulses only once 4 raw periods have been captured since reset or since the last timeout; after that it pulses on every raw period.
  - A timeout clears the history and the fill count.
- Not defined: `period_o` is the raw single-period count, and `valid_o` pulses on every completed period from the second rise onward.

## Test plan
Bench parameters are CNT_W = 8 and TIMEOUT = 200 unless stated.
- Reset behaviour: assert `rst_n` = 0 for 3 cycles with `sig_i` toggling → `period_o` = 0, `valid_o` = 0, `timeout_o` = 0 throughout. Release reset → no `valid_o` before the second detected rise.
- Steady square wave, period 20 cycles (10 high / 10 low), macro off → first `valid_o` 3 cycles after the 2nd rising `sig_i` sample, `period_o` = 20. Then `valid_o` pulses every 20 cycles with `period_o` = 20.
- Period change from 20 to 37 cycles, macro off → the first measurement spanning the new period reports 37, and `valid_o` stays a single-cycle pulse.
- Signal stuck low after two rises 50 cycles apart → `period_o` = 50 is held. `timeout_o` goes high 200 cycles after the last `rise`, with no `valid_o`. After resuming at period 30: the first rise re-arms, the second gives `period_o` = 30 with `valid_o`, and `timeout_o` clears in the same cycle.
- Mid-measurement reset: pulse `rst_n` low for 1 cycle 15 cycles into a 40-cycle period → all outputs 0, FSM in IDLE. The next rise produces no `valid_o`, and the following rise reports 40.
- Macro on, raw periods 20, 24, 28, 32 → no `valid_o` for the first three. At the 4th, `valid_o` = 1 and `period_o` = 26. A 5th period of 36 gives `period_o` = 30.
